// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction memory loader.
//   state_e        : loader FSM states (length capture, data capture, run)
//   DefaultNopInst : value presented on the fetch port when no fetch result is held
package inst_mem_pkg;

  typedef enum logic [1:0] {
    LoadLen,
    LoadData,
    Run
  } state_e;

  localparam logic [31:0] DefaultNopInst = 32'h0800_0000;

endpackage

// File: rtl/inst_ram.sv
// Inferred synchronous RAM: one write port, one read port, read latency 1.
// The array has no reset; contents survive reloads until overwritten.
// Ports:
//   clk_i            clock
//   we_i/waddr_i/wdata_i  write port
//   re_i/raddr_i     read request; data appears on rdata_o the next cycle
//   rdata_o          registered read data (holds until the next read)
module inst_ram #(
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AddrWidth;

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction memory with byte-stream program loader and fetch port.
// A big-endian byte stream supplies a length word N, then N instruction words that are
// written from address 0 upward (words past the end of the RAM are consumed, not written).
// Once loaded the block serves fetches with one cycle of latency.
// Optional feature macro: INST_MEM_DISTINCT_EN adds the change-detect (distinct_o) logic;
// without it distinct_o is tied low.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   load_start_i      abort everything and restart at length capture
//   byte_valid_i      byte_data_i is valid this cycle
//   byte_data_i       loader byte
//   fetch_en_i, pc_i  fetch request and word address (honoured only in Run)
//   inst_o            fetched instruction, NopInst when inst_valid_o is low
//   inst_valid_o      inst_o holds a fetch result
//   distinct_o        pulse: the fetched instruction differs from the previous one
//   loader_ready_o    one-cycle pulse on entering Run
//   loading_o         high while capturing length or data
module inst_mem_loader
  import inst_mem_pkg::*;
#(
  parameter int unsigned           InstMemWidth = 5,
  parameter int unsigned           InstWidth    = 32,
  parameter logic [InstWidth-1:0]  NopInst      = InstWidth'(DefaultNopInst)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    load_start_i,
  input  logic                    byte_valid_i,
  input  logic [7:0]              byte_data_i,
  input  logic                    fetch_en_i,
  input  logic [InstMemWidth-1:0] pc_i,
  output logic [InstWidth-1:0]    inst_o,
  output logic                    inst_valid_o,
  output logic                    distinct_o,
  output logic                    loader_ready_o,
  output logic                    loading_o
);

  localparam int unsigned Bpw      = InstWidth / 8;
  localparam int unsigned CntWidth = (Bpw > 1) ? $clog2(Bpw) : 1;
  // One extra bit so word indices past the RAM depth are recognisable.
  localparam int unsigned LenWidth = InstMemWidth + 1;

  localparam logic [CntWidth-1:0] LastByte = CntWidth'(Bpw - 1);
  localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);
  localparam logic [LenWidth-1:0] LenOne   = LenWidth'(1);

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   byte_cnt_q, byte_cnt_d;
  logic [InstWidth-1:0]  word_q, word_d;
  logic [LenWidth-1:0]   len_q, len_d;
  logic [LenWidth-1:0]   widx_q, widx_d;
  logic                  loader_ready_q, loader_ready_d;
  logic                  inst_valid_q, inst_valid_d;

  logic [InstWidth-1:0]  word_full;
  logic                  word_done;
  logic                  ram_we;
  logic                  fetch_accept;
  logic [InstWidth-1:0]  ram_rdata;

  // Shift the new byte in at the bottom: first byte ends up most significant.
  assign word_full = (word_q << 8) | InstWidth'(byte_data_i);
  assign word_done = (byte_cnt_q == LastByte);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    len_d      = len_q;
    widx_d     = widx_q;
    ram_we     = 1'b0;

    if (load_start_i) begin
      // Abort wins over any byte presented in the same cycle.
      state_d    = LoadLen;
      byte_cnt_d = '0;
      word_d     = '0;
      widx_d     = '0;
    end else begin
      unique case (state_q)
        LoadLen: begin
          if (byte_valid_i) begin
            if (word_done) begin
              byte_cnt_d = '0;
              word_d     = '0;
              len_d      = word_full[LenWidth-1:0];
              widx_d     = '0;
              state_d    = (word_full[LenWidth-1:0] == '0) ? Run : LoadData;
            end else begin
              byte_cnt_d = byte_cnt_q + CntOne;
              word_d     = word_full;
            end
          end
        end
        LoadData: begin
          if (byte_valid_i) begin
            if (word_done) begin
              byte_cnt_d = '0;
              word_d     = '0;
              // Indices at or beyond the depth are dropped rather than wrapped.
              ram_we     = ~widx_q[InstMemWidth];
              widx_d     = widx_q + LenOne;
              if (widx_q == len_q - LenOne) begin
                state_d = Run;
              end
            end else begin
              byte_cnt_d = byte_cnt_q + CntOne;
              word_d     = word_full;
            end
          end
        end
        Run: begin
        end
        default: state_d = LoadLen;
      endcase
    end
  end

  assign fetch_accept   = fetch_en_i && (state_q == Run) && !load_start_i;
  assign inst_valid_d   = fetch_accept;
  assign loader_ready_d = (state_d == Run) && (state_q != Run);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= LoadLen;
      byte_cnt_q     <= '0;
      word_q         <= '0;
      len_q          <= '0;
      widx_q         <= '0;
      loader_ready_q <= 1'b0;
      inst_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      word_q         <= word_d;
      len_q          <= len_d;
      widx_q         <= widx_d;
      loader_ready_q <= loader_ready_d;
      inst_valid_q   <= inst_valid_d;
    end
  end

  inst_ram #(
    .AddrWidth(InstMemWidth),
    .DataWidth(InstWidth)
  ) u_inst_ram (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .waddr_i(widx_q[InstMemWidth-1:0]),
    .wdata_i(word_full),
    .re_i   (fetch_accept),
    .raddr_i(pc_i),
    .rdata_o(ram_rdata)
  );

  assign inst_o         = inst_valid_q ? ram_rdata : NopInst;
  assign inst_valid_o   = inst_valid_q;
  assign loader_ready_o = loader_ready_q;
  assign loading_o      = (state_q != Run);

`ifdef INST_MEM_DISTINCT_EN
  logic [InstWidth-1:0] buf_q;
  logic                 first_q;
  logic                 distinct_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q      <= '0;
      first_q    <= 1'b1;
      distinct_q <= 1'b0;
    end else begin
      distinct_q <= inst_valid_q && (first_q || (ram_rdata != buf_q));
      if (inst_valid_q) begin
        buf_q <= ram_rdata;
      end
      // A fresh program always reports its first fetch as distinct.
      if (loader_ready_d) begin
        first_q <= 1'b1;
      end else if (inst_valid_q) begin
        first_q <= 1'b0;
      end
    end
  end

  assign distinct_o = distinct_q;
`else
  assign distinct_o = 1'b0;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

  localparam int unsigned Bpw   = 4;
  localparam int unsigned Depth = 32;
  localparam logic [31:0] Nop   = 32'h0800_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        fetch_en = 1'b0;
  logic [4:0]  pc = '0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        distinct;
  logic        loader_ready;
  logic        loading;

  always #5 clk = ~clk;

  inst_mem_loader dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .load_start_i  (load_start),
    .byte_valid_i  (byte_valid),
    .byte_data_i   (byte_data),
    .fetch_en_i    (fetch_en),
    .pc_i          (pc),
    .inst_o        (inst),
    .inst_valid_o  (inst_valid),
    .distinct_o    (distinct),
    .loader_ready_o(loader_ready),
    .loading_o     (loading)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: memory image plus change-detect history.
  logic [31:0] mem_m [Depth];
  bit          first_m = 1'b1;
  logic [31:0] last_m = '0;

  logic [31:0] ld_words[$];
  bit          ld_early, ld_ready, ld_leak;

  bit          f_en [64];
  int          f_pc [64];
  logic [31:0] exp_inst [64];
  bit          exp_valid [64];
  bit          exp_dist [64];
  logic [31:0] obs_inst [65];
  logic        obs_valid [65];
  logic        obs_dist [65];
  logic        obs_ready [65];

  task automatic model_fetch(input bit en, input int p, output logic [31:0] ei, output bit ev,
                             output bit ed);
    ev = en;
    ei = Nop;
    ed = 1'b0;
    if (en) begin
      ei = mem_m[p];
`ifdef INST_MEM_DISTINCT_EN
      ed = first_m || (mem_m[p] != last_m);
`endif
      last_m  = mem_m[p];
      first_m = 1'b0;
    end
  endtask

  task automatic drive_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  // Full load: load_start (with a junk byte alongside), length word, data words, random gaps
  // and random fetch requests throughout. Returns at the cycle after the final byte.
  task automatic load_program(input int n, input bit junk_hi);
    logic [31:0] lenw;
    logic [31:0] w;
    logic [7:0]  bytes[$];
    lenw = junk_hi ? (($urandom & 32'hFFFF_FFC0) | 32'(n)) : 32'(n);
    for (int k = Bpw - 1; k >= 0; k--) bytes.push_back(lenw[8*k +: 8]);
    for (int i = 0; i < n; i++) begin
      w = ld_words[i];
      for (int k = Bpw - 1; k >= 0; k--) bytes.push_back(w[8*k +: 8]);
    end
    ld_early = 1'b0;
    ld_leak  = 1'b0;
    load_start = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'($urandom);
    @(negedge clk);
    load_start = 1'b0;
    byte_valid = 1'b0;
    for (int i = 0; i < bytes.size(); i++) begin
      repeat ($urandom_range(0, 1)) begin
        fetch_en = 1'($urandom);
        pc       = 5'($urandom);
        @(negedge clk);
        if (loader_ready) ld_early = 1'b1;
        if (inst_valid) ld_leak = 1'b1;
      end
      fetch_en = 1'($urandom);
      pc       = 5'($urandom);
      drive_byte(bytes[i]);
      if (i < bytes.size() - 1 && loader_ready) ld_early = 1'b1;
      if (inst_valid) ld_leak = 1'b1;
    end
    fetch_en = 1'b0;
    ld_ready = loader_ready;
    for (int i = 0; i < n && i < Depth; i++) mem_m[i] = ld_words[i];
    first_m = 1'b1;
  endtask

  // Drives f_en/f_pc for n cycles starting now; records outputs and model expectations.
  task automatic fetch_burst(input int n);
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        fetch_en = f_en[i];
        pc       = 5'(f_pc[i]);
        model_fetch(f_en[i], f_pc[i], exp_inst[i], exp_valid[i], exp_dist[i]);
      end else begin
        fetch_en = 1'b0;
      end
      @(negedge clk);
      obs_inst[i]  = inst;
      obs_valid[i] = inst_valid;
      obs_dist[i]  = distinct;
      obs_ready[i] = loader_ready;
    end
    fetch_en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if (inst !== Nop) begin
      tests_failed++; $display("FAIL reset_inst: got %h, expected %h", inst, Nop);
    end
    tests_run++;
    if ({inst_valid, distinct, loader_ready, loading} !== 4'b0001) begin
      tests_failed++;
      $display("FAIL reset_flags: got valid/dist/ready/loading=%b, expected 0001",
               {inst_valid, distinct, loader_ready, loading});
    end
    rst_n = 1'b1;
    fetch_en = 1'b1;
    pc = 5'd3;
    repeat (2) begin
      @(negedge clk);
      tests_run++;
      if (inst_valid !== 1'b0 || inst !== Nop) begin
        tests_failed++;
        $display("FAIL fetch_before_load: got valid=%b inst=%h, expected 0 %h", inst_valid, inst,
                 Nop);
      end
    end
    fetch_en = 1'b0;
  endtask

  task automatic test_basic();
    ld_words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    load_program(3, 1'b0);
    tests_run++;
    if ({ld_early, ld_ready, ld_leak, loading} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL basic_load: got early/ready/leak/loading=%b, expected 0100",
               {ld_early, ld_ready, ld_leak, loading});
    end
    for (int i = 0; i < 3; i++) begin f_en[i] = 1'b1; f_pc[i] = i; end
    fetch_burst(3);
    tests_run++;
    if (obs_ready[0] !== 1'b0) begin
      tests_failed++; $display("FAIL basic_ready_width: got %b, expected 0", obs_ready[0]);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (obs_valid[i] !== exp_valid[i] || obs_inst[i] !== exp_inst[i] ||
          obs_dist[i+1] !== exp_dist[i]) begin
        tests_failed++;
        $display("FAIL basic_fetch[%0d]: got v=%b i=%h d=%b, expected v=%b i=%h d=%b", i,
                 obs_valid[i], obs_inst[i], obs_dist[i+1], exp_valid[i], exp_inst[i],
                 exp_dist[i]);
      end
    end
  endtask

  task automatic test_repeat();
    for (int i = 0; i < 4; i++) begin f_en[i] = 1'b1; f_pc[i] = 1; end
    fetch_burst(4);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (obs_valid[i] !== exp_valid[i] || obs_inst[i] !== exp_inst[i] ||
          obs_dist[i+1] !== exp_dist[i]) begin
        tests_failed++;
        $display("FAIL repeat_fetch[%0d]: got v=%b i=%h d=%b, expected v=%b i=%h d=%b", i,
                 obs_valid[i], obs_inst[i], obs_dist[i+1], exp_valid[i], exp_inst[i],
                 exp_dist[i]);
      end
    end
  endtask

  task automatic test_overflow();
    ld_words = {};
    for (int i = 0; i < 34; i++) ld_words.push_back($urandom);
    load_program(34, 1'b1);
    tests_run++;
    if ({ld_early, ld_ready, ld_leak} !== 3'b010) begin
      tests_failed++;
      $display("FAIL overflow_load: got early/ready/leak=%b, expected 010",
               {ld_early, ld_ready, ld_leak});
    end
    f_en[0] = 1'b1; f_pc[0] = 0;
    f_en[1] = 1'b1; f_pc[1] = 31;
    f_en[2] = 1'b1; f_pc[2] = 1;
    for (int i = 3; i < 12; i++) begin f_en[i] = 1'b1; f_pc[i] = $urandom_range(0, 31); end
    fetch_burst(12);
    for (int i = 0; i < 12; i++) begin
      tests_run++;
      if (obs_valid[i] !== exp_valid[i] || obs_inst[i] !== exp_inst[i] ||
          obs_dist[i+1] !== exp_dist[i]) begin
        tests_failed++;
        $display("FAIL overflow_fetch[%0d]: got v=%b i=%h d=%b, expected v=%b i=%h d=%b", i,
                 obs_valid[i], obs_inst[i], obs_dist[i+1], exp_valid[i], exp_inst[i],
                 exp_dist[i]);
      end
    end
  endtask

  task automatic test_len_zero();
    ld_words = {};
    load_program(0, 1'b1);
    tests_run++;
    if ({ld_early, ld_ready, ld_leak} !== 3'b010) begin
      tests_failed++;
      $display("FAIL len_zero_load: got early/ready/leak=%b, expected 010",
               {ld_early, ld_ready, ld_leak});
    end
    for (int i = 0; i < 10; i++) begin
      f_en[i] = ($urandom_range(0, 3) != 0);
      f_pc[i] = $urandom_range(0, 31);
    end
    fetch_burst(10);
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (obs_valid[i] !== exp_valid[i] || obs_inst[i] !== exp_inst[i] ||
          obs_dist[i+1] !== exp_dist[i]) begin
        tests_failed++;
        $display("FAIL len_zero_fetch[%0d]: got v=%b i=%h d=%b, expected v=%b i=%h d=%b", i,
                 obs_valid[i], obs_inst[i], obs_dist[i+1], exp_valid[i], exp_inst[i],
                 exp_dist[i]);
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] w0, w1;
    w0 = $urandom;
    w1 = $urandom;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int k = Bpw - 1; k >= 0; k--) drive_byte((k == 0) ? 8'd2 : 8'd0);
    for (int k = Bpw - 1; k >= 0; k--) drive_byte(w0[8*k +: 8]);
    mem_m[0] = w0;
    drive_byte(w1[31:24]);
    drive_byte(w1[23:16]);
    tests_run++;
    if (loading !== 1'b1 || loader_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_midload: got loading=%b ready=%b, expected 1 0", loading, loader_ready);
    end
    ld_words = '{32'hDEAD_BEEF};
    load_program(1, 1'b0);
    tests_run++;
    if ({ld_early, ld_ready, ld_leak} !== 3'b010) begin
      tests_failed++;
      $display("FAIL abort_reload: got early/ready/leak=%b, expected 010",
               {ld_early, ld_ready, ld_leak});
    end
    f_en[0] = 1'b1; f_pc[0] = 0;
    f_en[1] = 1'b1; f_pc[1] = 1;
    fetch_burst(2);
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (obs_valid[i] !== exp_valid[i] || obs_inst[i] !== exp_inst[i] ||
          obs_dist[i+1] !== exp_dist[i]) begin
        tests_failed++;
        $display("FAIL abort_fetch[%0d]: got v=%b i=%h d=%b, expected v=%b i=%h d=%b", i,
                 obs_valid[i], obs_inst[i], obs_dist[i+1], exp_valid[i], exp_inst[i],
                 exp_dist[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] wa, wb;
    wa = $urandom;
    wb = $urandom;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int k = Bpw - 1; k >= 0; k--) drive_byte((k == 0) ? 8'd4 : 8'd0);
    for (int k = Bpw - 1; k >= 0; k--) drive_byte(wa[8*k +: 8]);
    mem_m[0] = wa;
    drive_byte(wb[31:24]);
    drive_byte(wb[23:16]);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (inst !== Nop || {inst_valid, distinct, loader_ready, loading} !== 4'b0001) begin
      tests_failed++;
      $display("FAIL async_reset: got inst=%h v/d/r/l=%b, expected %h 0001", inst,
               {inst_valid, distinct, loader_ready, loading}, Nop);
    end
    @(negedge clk);
    rst_n = 1'b1;
    first_m = 1'b1;
    fetch_en = 1'b1;
    pc = 5'd0;
    repeat (2) begin
      @(negedge clk);
      tests_run++;
      if (inst_valid !== 1'b0 || loading !== 1'b1) begin
        tests_failed++;
        $display("FAIL post_reset_fetch: got valid=%b loading=%b, expected 0 1", inst_valid,
                 loading);
      end
    end
    fetch_en = 1'b0;
    // A length of zero must be taken as a fresh length word, not as data of the lost load.
    for (int k = 0; k < Bpw; k++) drive_byte(8'd0);
    tests_run++;
    if (loader_ready !== 1'b1) begin
      tests_failed++; $display("FAIL post_reset_len0_ready: got %b, expected 1", loader_ready);
    end
    first_m = 1'b1;
    for (int i = 0; i < 6; i++) begin f_en[i] = 1'b1; f_pc[i] = (i < 2) ? i : $urandom_range(0, 31); end
    fetch_burst(6);
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (obs_valid[i] !== exp_valid[i] || obs_inst[i] !== exp_inst[i] ||
          obs_dist[i+1] !== exp_dist[i]) begin
        tests_failed++;
        $display("FAIL reset_fetch[%0d]: got v=%b i=%h d=%b, expected v=%b i=%h d=%b", i,
                 obs_valid[i], obs_inst[i], obs_dist[i+1], exp_valid[i], exp_inst[i],
                 exp_dist[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pool [4];
    int          n;
    for (int i = 0; i < 4; i++) pool[i] = $urandom;
    repeat (3) begin
      n = $urandom_range(1, 40);
      ld_words = {};
      for (int i = 0; i < n; i++) ld_words.push_back(pool[$urandom_range(0, 3)]);
      load_program(n, 1'($urandom));
      tests_run++;
      if ({ld_early, ld_ready, ld_leak} !== 3'b010) begin
        tests_failed++;
        $display("FAIL b2b_load(n=%0d): got early/ready/leak=%b, expected 010", n,
                 {ld_early, ld_ready, ld_leak});
      end
      for (int i = 0; i < 40; i++) begin
        f_en[i] = ($urandom_range(0, 3) != 0);
        f_pc[i] = $urandom_range(0, 31);
      end
      fetch_burst(40);
      for (int i = 0; i < 40; i++) begin
        tests_run++;
        if (obs_valid[i] !== exp_valid[i] || obs_inst[i] !== exp_inst[i] ||
            obs_dist[i+1] !== exp_dist[i]) begin
          tests_failed++;
          $display("FAIL b2b_fetch[%0d]: got v=%b i=%h d=%b, expected v=%b i=%h d=%b", i,
                   obs_valid[i], obs_inst[i], obs_dist[i+1], exp_valid[i], exp_inst[i],
                   exp_dist[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_repeat();
    test_overflow();
    test_len_zero();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Parametrised instruction memory with built-in program loader and fetch handshake, the next generation of the core's instruction store. Assembles a byte stream from the UART receiver into instruction words, writes them into an inferred synchronous RAM, then serves fetches from the PC stage with a valid strobe and a change-detect (`distinct`) flag. It sits between the UART receiver, the fetch stage and the core's start logic; `loader_ready` releases the core.

## Interface
- `INST_MEM_WIDTH`, 5: address bits; depth = 2**INST_MEM_WIDTH words.
- `INST_WIDTH`, 32: instruction width; must be a multiple of 8; BPW = INST_WIDTH/8 bytes per word.
- `NOP_INST`, 32'h08000000: value driven on `inst` whenever `inst_valid`=0.
- `CLK` in 1: sole clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `load_start` in 1: pulse; abort any activity and enter `LOAD_LEN`.
- `byte_valid` in 1: `byte_data` valid this cycle.
- `byte_data` in 8: loader byte, big-endian within a word.
- `fetch_en` in 1: fetch request at `pc`.
- `pc` in INST_MEM_WIDTH: word address.
- `inst` out INST_WIDTH: fetched instruction.
- `inst_valid` out 1: `inst` holds a fetch result.
- `distinct` out 1: last fetched instruction differs from the previous one.
- `loader_ready` out 1: one-cycle pulse on entering `RUN`.
- `loading` out 1: high in `LOAD_LEN`/`LOAD_DATA`.

## Operation
- States: `LOAD_LEN` → `LOAD_DATA` → `RUN`; reset state `LOAD_LEN`.
- `LOAD_LEN`: collect BPW bytes into length N (low INST_MEM_WIDTH+1 bits used, upper bits ignored). N=0 → `RUN` directly; else → `LOAD_DATA`, write address 0.
- `LOAD_DATA`: every BPW bytes form one word; written at current address, address increments. Words with index ≥ depth are consumed but not written (no wrap). After word N-1 completes → `RUN`.
- `RUN`: `byte_valid` ignored. `fetch_en` reads RAM[`pc`].
- `load_start` from any state: partial byte assembly discarded, byte arriving same cycle ignored, state ← `LOAD_LEN`, `inst_valid` ← 0 next cycle. RAM contents retained until overwritten.
- `fetch_en` outside `RUN` ignored.
- Distinct: comparison buffer holds last valid `inst`. First valid fetch after reset or after `loader_ready` always gives `distinct`=1.

## Timing
- Reset values: `inst`=NOP_INST, `inst_valid`=0, `distinct`=0, `loader_ready`=0, `loading`=1; byte counter, write address and buffer cleared.
- Fetch latency 1: `fetch_en` at cycle t → `inst`/`inst_valid` at t+1; `distinct` for that fetch at t+2 (one cycle pulse per valid fetch).
- Back-to-back fetches sustained every cycle.
- `loader_ready` high exactly the cycle after the final byte (or the final length byte when N=0); first fetch accepted that same cycle.
- Write happens the cycle after the BPW-th byte of a word; a fetch in that cycle is impossible (not `RUN`).
- Reset asserted mid-load: all load progress lost, state `LOAD_LEN`.

## Configuration
- `INST_MEM_DISTINCT_EN`: defined → comparison buffer, first-fetch flag and `distinct` logic present. Undefined → `distinct` tied 0, no buffer registers.

## Structure
- Shared package `inst_mem_pkg`: state enum (`LOAD_LEN`, `LOAD_DATA`, `RUN`), default NOP_INST constant.
- One sub-module `inst_ram`: single-port-write/single-port-read synchronous RAM, depth 2**INST_MEM_WIDTH, width INST_WIDTH, read latency 1, no reset on array.

## Test plan
- Reset, stream length 3 then words 0x11111111, 0x22222222, 0x33333333 → `loader_ready` pulse one cycle after 16th byte; fetch pc=0,1,2 → 0x11111111, 0x22222222, 0x33333333 at t+1, `distinct`=1 each at t+2.
- Fetch pc=1 four consecutive cycles → `inst_valid` 4 cycles, `distinct` 1,0,0,0.
- Length 0 → `loader_ready` one cycle after 4th byte, no RAM writes (previous contents readable).
- Depth 32, length 34 → 34 words consumed, addresses 0–31 written, word 32/33 dropped, pc=0 still first word.
- `load_start` after 2 bytes of a data word, then full reload of length 1 word 0xDEADBEEF → pc=0 reads 0xDEADBEEF, no stale partial bytes.
- `reset_n` pulsed low mid-`LOAD_DATA` asynchronously → outputs at reset values immediately, `loading`=1, `fetch_en` ignored until new load completes.
